// File: rtl/stp_frame_rcvr.sv
// Asynchronous serial frame receiver.
// Frame: one start bit (0), NUM_BITS data bits MSB first, one stop bit (1).
// The line is double-synchronised and oversampled by a BIT_PERIOD-cycle timer.
// A good frame is loaded into rx_data; unread overwrites raise overrun_error.
module stp_frame_rcvr #(
    parameter int unsigned NUM_BITS   = 8,
    parameter int unsigned BIT_PERIOD = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                serial_in,
    input  logic                data_read,
    output logic [NUM_BITS-1:0] rx_data,
    output logic                data_ready,
    output logic                overrun_error,
    output logic                framing_error,
    output logic                rx_busy
);

    localparam int unsigned TW = $clog2(BIT_PERIOD);
    localparam int unsigned CW = $clog2(NUM_BITS + 1);

    // Start bit is re-checked half a bit in; data and stop are sampled a full bit later.
    localparam logic [TW-1:0] HALF_LAST = TW'(BIT_PERIOD / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(BIT_PERIOD - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(NUM_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StDone
    } state_e;

    state_e              state_q;
    logic [TW-1:0]       timer_q;
    logic [CW-1:0]       bit_cnt_q;
    logic [NUM_BITS-1:0] shift_q;
    logic                stop_bit_q;
    logic                sync_meta_q;
    logic                sync_in;
    logic                sync_prev;

    // Line synchroniser plus one-cycle delayed copy for falling-edge detection.
    // All flops preset to 1 so an idle line after reset never looks like a start.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta_q <= 1'b1;
            sync_in     <= 1'b1;
            sync_prev   <= 1'b1;
        end else begin
            sync_meta_q <= serial_in;
            sync_in     <= sync_meta_q;
            sync_prev   <= sync_in;
        end
    end

    // Receive FSM with registered payload and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            timer_q       <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            stop_bit_q    <= 1'b0;
            rx_data       <= '0;
            data_ready    <= 1'b0;
            overrun_error <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            // Consumer acknowledge; a load in StDone below takes precedence.
            if (data_read && data_ready) begin
                data_ready    <= 1'b0;
                overrun_error <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (sync_prev && !sync_in) begin
                        state_q <= StStart;
                        timer_q <= '0;
                    end
                end
                StStart: begin
                    if (timer_q == HALF_LAST) begin
                        timer_q <= '0;
                        if (!sync_in) begin
                            state_q   <= StData;
                            bit_cnt_q <= '0;
                        end else begin
                            // Low pulse shorter than half a bit: treat as noise.
                            state_q <= StIdle;
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                StData: begin
                    if (timer_q == BIT_LAST) begin
                        timer_q   <= '0;
                        shift_q   <= {shift_q[NUM_BITS-2:0], sync_in};
                        bit_cnt_q <= bit_cnt_q + CW'(1);
                        if (bit_cnt_q == CNT_LAST) begin
                            state_q <= StStop;
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                StStop: begin
                    if (timer_q == BIT_LAST) begin
                        timer_q    <= '0;
                        stop_bit_q <= sync_in;
                        state_q    <= StDone;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                StDone: begin
                    if (stop_bit_q) begin
                        rx_data       <= shift_q;
                        data_ready    <= 1'b1;
                        framing_error <= 1'b0;
                        // Overrun only if the old frame is lost unread this very cycle.
                        overrun_error <= data_ready && !data_read;
                    end else begin
                        framing_error <= 1'b1;
                    end
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign rx_busy = (state_q != StIdle);

endmodule
